writeback_queue: RTL and testbench
==================================

# writeback_queue

Write-side front end for the 16 x 20-bit `register_file`. The block accepts register-write requests from the execution stage through a valid/ready handshake. It buffers them in a small in-order FIFO and drives the register file's single write port (`write`, `w_select`, `w`) with one entry per cycle. While entries wait in the queue, it forwards the newest pending value for the two read selects, so readers never see stale data.

## Interface

Parameters:
- `DEPTH`, default 4: queue entries; power of two, 2..16.
- `WIDTH`, default 20: data width; must match the register file.

Ports:
- `clk`  in  1  rising-edge clock, shared with `register_file`.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  a write request is present.
- `in_ready`  out  1  the queue can accept a request this cycle.
- `in_sel`  in  4  destination register index.
- `in_data`  in  WIDTH  value to write.
- `rf_busy`  in  1  register-file write port is claimed elsewhere this cycle; no drain.
- `w`  out  1  write enable to `register_file`.
- `w_select`  out  4  write index to `register_file`.
- `write`  out  WIDTH  write data to `register_file`.
- `r1_select`, `r2_select`  in  4 each  the same selects that drive the register-file read ports.
- `fwd1_hit`, `fwd2_hit`  out  1 each  a pending entry matches the corresponding select.
- `fwd1_data`, `fwd2_data`  out  WIDTH each  newest pending value for the select; 0 when no hit.
- `count`  out  log2(DEPTH)+1  number of occupied entries.

## Operation

- Storage is a circular buffer of DEPTH entries, each holding {sel[3:0], data}. It has read and write pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus an occupancy counter.
- Push: occurs when `in_valid & in_ready` at a clock edge. The entry is stored at the write pointer, the pointer advances, and `count` increments.
- `in_ready` = (`count` < DEPTH). When the queue is full, `in_ready` is 0 even if a pop happens in the same cycle; push-on-full is never accepted.
- Drain (combinational from the head):
  - `w` = (`count` != 0) & !`rf_busy`.
  - `w_select` and `write` show the head entry's sel and data.
  - When the queue is empty, `w_select` and `write` are 0.
- Pop: occurs at any edge where `w` = 1. This is the same edge at which `register_file` captures the write. The read pointer advances and `count` decrements.
- Simultaneous push and pop: `count` is unchanged and both pointers advance.
- Entries drain strictly in arrival order. Multiple pending writes to the same register are all performed, in order, with no coalescing.
- Forwarding (combinational) for each read port k:
  - Search every occupied entry, including the head being drained this cycle.
  - `fwdk_hit` = 1 if any occupied entry's sel equals `rk_select`.
  - `fwdk_data` is the data of the newest matching entry, i.e. the one closest to the write pointer.
  - An entry being pushed in the current cycle is not yet visible to forwarding.
  - Consumers use `fwdk_data` when `fwdk_hit` = 1, and `register_file` `readk` otherwise.
- Register 0 is an ordinary register with no special case.

## Timing

- Reset (asynchronous, any time): pointers = 0, `count` = 0. This forces `w` = 0, `in_ready` = 1, `w_select`/`write` = 0, `fwd*_hit` = 0 and `fwd*_data` = 0. Queued entries are discarded; reset mid-drain loses them by design.
- Latency with `rf_busy` = 0:
  - Request accepted at edge N.
  - Visible to forwarding and at the head after edge N (if the queue was empty).
  - Committed into `register_file` at edge N+1.
  - Minimum push-to-commit latency is 1 cycle; throughput is 1 write per cycle.
- While `rf_busy` = 1: the head is held, `w` = 0, the queue fills, and `in_ready` drops once `count` = DEPTH.
- Forwarding paths are combinational from `r*_select` and the queue state. Hit and data are valid in the same cycle the selects change.
- Pointer wrap: after DEPTH pushes the write pointer returns to 0. The full/empty distinction relies on `count` only.

## Test plan

- Reset then idle: assert `rst` asynchronously between edges. Required: `w` = 0, `in_ready` = 1, `count` = 0 and `fwd1_hit` = 0 immediately, without waiting for a clock edge.
- Single write: push sel=5, data=20'hABCDE with `rf_busy` = 0.
  - Next cycle: `w` = 1, `w_select` = 5, `write` = 20'hABCDE, and `fwd1_hit` = 1 with `r1_select` = 5.
  - One edge later: `count` = 0, and `register_file` read of 5 returns 20'hABCDE.
- Fill and stall: hold `rf_busy` = 1 and push 4 entries, sel 1..4. Required: `count` = 4 and `in_ready` = 0; a 5th `in_valid` is not accepted. Release `rf_busy`: the writes appear in the order 1, 2, 3, 4 over 4 consecutive cycles.
- Newest-wins forwarding: with `rf_busy` = 1, push sel=7 data=1, then sel=7 data=2. Required: `fwd2_hit` = 1 and `fwd2_data` = 2 for `r2_select` = 7. After the first drain, still 2. After the second drain, `fwd2_hit` = 0 and the register holds 2.
- Simultaneous push/pop with wrap: stream 10 pushes with `rf_busy` = 0 and `in_valid` held high. Required: `count` stays at 1, pointers wrap past DEPTH, and all 10 values land in order with no drops.
- Reset mid-operation: with 3 entries queued, pulse `rst`. Required: the queue empties, none of the 3 writes reaches `register_file`, and the next push behaves as in the single-write test.

Source files
------------

// File: rtl/writeback_queue.sv
// In-order write queue in front of the 16-entry register file: buffers write
// requests, drains one per cycle into the write port, and forwards pending values.
module writeback_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 20
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               in_sel,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     rf_busy,
    output logic                     w,
    output logic [3:0]               w_select,
    output logic [WIDTH-1:0]         write,
    input  logic [3:0]               r1_select,
    input  logic [3:0]               r2_select,
    output logic                     fwd1_hit,
    output logic                     fwd2_hit,
    output logic [WIDTH-1:0]         fwd1_data,
    output logic [WIDTH-1:0]         fwd2_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [3:0]       r_sel  [DEPTH];
    logic [WIDTH-1:0] r_data [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;

    logic w_push;
    logic w_pop;
    logic w_empty;

    assign w_empty  = (r_count == '0);
    // Full blocks a push even if the head drains this same cycle.
    assign in_ready = (r_count != FULL);
    assign w_push   = in_valid & in_ready;
    assign w_pop    = ~w_empty & ~rf_busy;

    assign w        = w_pop;
    assign w_select = w_empty ? 4'd0 : r_sel[r_rptr];
    assign write    = w_empty ? '0   : r_data[r_rptr];
    assign count    = r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_sel[r_wptr]  <= in_sel;
            r_data[r_wptr] <= in_data;
        end
    end

    // Scan oldest to newest so the last match (closest to the write pointer) wins.
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
        logic [3:0]       w_key;
        logic             w_hit;
        logic [WIDTH-1:0] w_val;

        assign w_key = (gi == 0) ? r1_select : r2_select;

        always_comb begin
            w_hit = 1'b0;
            w_val = '0;
            for (int a = 0; a < DEPTH; a++) begin
                if (((AW+1)'(a) < r_count) && (r_sel[r_rptr + AW'(a)] == w_key)) begin
                    w_hit = 1'b1;
                    w_val = r_data[r_rptr + AW'(a)];
                end
            end
        end
    end

    assign fwd1_hit  = g_fwd[0].w_hit;
    assign fwd1_data = g_fwd[0].w_val;
    assign fwd2_hit  = g_fwd[1].w_hit;
    assign fwd2_data = g_fwd[1].w_val;

endmodule

// File: tb/tb_writeback_queue.sv
// Bench for writeback_queue: directed scenarios with literal expectations, then
// random traffic compared every cycle against a queue-based reference model.
module tb_writeback_queue;
    localparam int DEPTH = 4;
    localparam int WIDTH = 20;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [3:0]       in_sel = '0;
    logic [WIDTH-1:0] in_data = '0;
    logic             rf_busy = 1'b0;
    logic             w;
    logic [3:0]       w_select;
    logic [WIDTH-1:0] write;
    logic [3:0]       r1_select = '0;
    logic [3:0]       r2_select = '0;
    logic             fwd1_hit, fwd2_hit;
    logic [WIDTH-1:0] fwd1_data, fwd2_data;
    logic [2:0]       count;

    writeback_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
        .rf_busy(rf_busy),
        .w(w), .w_select(w_select), .write(write),
        .r1_select(r1_select), .r2_select(r2_select),
        .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
        .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]       sel;
        logic [WIDTH-1:0] data;
    } ent_t;

    ent_t             q[$];
    logic [WIDTH-1:0] tb_rf [16];
    int               n_checks = 0;
    int               n_fail = 0;

    logic             s_w, s_ready, s_h1, s_h2;
    logic [3:0]       s_wsel;
    logic [WIDTH-1:0] s_write, s_d1, s_d2;
    logic [2:0]       s_count;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fwd_model(input logic [3:0] key, output logic hit, output logic [WIDTH-1:0] val);
        hit = 1'b0;
        val = '0;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (!hit && q[i].sel == key) begin
                hit = 1'b1;
                val = q[i].data;
            end
        end
    endtask

    // One clock cycle: drive inputs, compare every output against the model,
    // then advance the model and the bench's register-file image at the edge.
    task automatic step(input logic v, input logic [3:0] s, input logic [WIDTH-1:0] d,
                        input logic b, input logic [3:0] a1, input logic [3:0] a2);
        int               n;
        logic             e_w, e_ready, e_h1, e_h2;
        logic [3:0]       e_sel;
        logic [WIDTH-1:0] e_data, e_d1, e_d2;
        @(negedge clk);
        in_valid = v; in_sel = s; in_data = d; rf_busy = b;
        r1_select = a1; r2_select = a2;
        #1;
        n       = q.size();
        e_ready = (n < DEPTH);
        e_w     = (n != 0) && !b;
        e_sel   = (n != 0) ? q[0].sel : 4'd0;
        e_data  = (n != 0) ? q[0].data : '0;
        fwd_model(a1, e_h1, e_d1);
        fwd_model(a2, e_h2, e_d2);
        chk("count", count, n);
        chk("in_ready", in_ready, e_ready);
        chk("w", w, e_w);
        chk("w_select", w_select, e_sel);
        chk("write", write, e_data);
        chk("fwd1_hit", fwd1_hit, e_h1);
        chk("fwd1_data", fwd1_data, e_d1);
        chk("fwd2_hit", fwd2_hit, e_h2);
        chk("fwd2_data", fwd2_data, e_d2);
        s_w = w; s_ready = in_ready; s_wsel = w_select; s_write = write;
        s_h1 = fwd1_hit; s_d1 = fwd1_data; s_h2 = fwd2_hit; s_d2 = fwd2_data; s_count = count;
        @(posedge clk);
        if (s_w) tb_rf[s_wsel] = s_write;
        if (e_w) void'(q.pop_front());
        if (v && e_ready) q.push_back('{sel: s, data: d});
        #1;
    endtask

    task automatic idle(input logic b, input logic [3:0] a1, input logic [3:0] a2);
        step(1'b0, 4'd0, '0, b, a1, a2);
    endtask

    // Reset is raised between edges and checked before any clock edge arrives.
    task automatic do_reset(input logic [3:0] probe);
        @(negedge clk);
        in_valid = 1'b0; rf_busy = 1'b0; r1_select = probe; r2_select = probe;
        #2 rst = 1'b1;
        #1;
        chk("rst_w", w, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_count", count, 3'd0);
        chk("rst_fwd1_hit", fwd1_hit, 1'b0);
        chk("rst_fwd1_data", fwd1_data, 20'd0);
        chk("rst_w_select", w_select, 4'd0);
        chk("rst_write", write, 20'd0);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic single_write(input logic [WIDTH-1:0] d);
        step(1'b1, 4'd5, d, 1'b0, 4'd5, 4'd0);
        idle(1'b0, 4'd5, 4'd0);
        chk("single_w", s_w, 1'b1);
        chk("single_w_select", s_wsel, 4'd5);
        chk("single_write", s_write, d);
        chk("single_fwd1_hit", s_h1, 1'b1);
        chk("single_fwd1_data", s_d1, d);
        idle(1'b0, 4'd5, 4'd0);
        chk("single_count_after", s_count, 3'd0);
        chk("single_rf5", tb_rf[5], d);
    endtask

    initial begin
        logic [WIDTH-1:0] saved [3];
        for (int i = 0; i < 16; i++) tb_rf[i] = '0;

        do_reset(4'd0);

        single_write(20'hABCDE);

        // Fill while the write port is busy, then drain in arrival order.
        for (int i = 1; i <= 4; i++) step(1'b1, 4'(i), 20'(16 * i), 1'b1, 4'd0, 4'd0);
        step(1'b1, 4'd9, 20'hFFFFF, 1'b1, 4'd0, 4'd0);
        chk("fill_count", s_count, 3'd4);
        chk("fill_in_ready", s_ready, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            idle(1'b0, 4'd0, 4'd0);
            chk("drain_w", s_w, 1'b1);
            chk("drain_order", s_wsel, 4'(i));
        end
        idle(1'b0, 4'd9, 4'd0);
        chk("drain_empty", s_count, 3'd0);
        chk("no_fifth_fwd", s_h1, 1'b0);

        // Two pending writes to one register: the newer value is forwarded.
        step(1'b1, 4'd7, 20'd1, 1'b1, 4'd0, 4'd7);
        step(1'b1, 4'd7, 20'd2, 1'b1, 4'd0, 4'd7);
        idle(1'b1, 4'd0, 4'd7);
        chk("newest_hit", s_h2, 1'b1);
        chk("newest_data", s_d2, 20'd2);
        idle(1'b0, 4'd0, 4'd7);
        chk("newest_data_drain0", s_d2, 20'd2);
        idle(1'b0, 4'd0, 4'd7);
        chk("newest_data_drain1", s_d2, 20'd2);
        idle(1'b0, 4'd0, 4'd7);
        chk("newest_gone", s_h2, 1'b0);
        chk("newest_rf7", tb_rf[7], 20'd2);

        // Streaming: push and pop every cycle, pointers wrap twice.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 4'(i), 20'(100 + i), 1'b0, 4'd0, 4'd0);
            chk("stream_count", s_count, (i == 0) ? 3'd0 : 3'd1);
        end
        idle(1'b0, 4'd0, 4'd0);
        chk("stream_tail", s_wsel, 4'd9);
        idle(1'b0, 4'd0, 4'd0);
        for (int i = 0; i < 10; i++) chk("stream_rf", tb_rf[i], 20'(100 + i));

        // Reset with entries queued: none of them may reach the register file.
        for (int i = 0; i < 3; i++) saved[i] = tb_rf[10 + i];
        for (int i = 0; i < 3; i++) step(1'b1, 4'(10 + i), 20'hC0DE0 + 20'(i), 1'b1, 4'd0, 4'd0);
        do_reset(4'd11);
        for (int i = 0; i < 3; i++) begin
            idle(1'b0, 4'd11, 4'd12);
            chk("postrst_w", s_w, 1'b0);
        end
        for (int i = 0; i < 3; i++) chk("postrst_rf", tb_rf[10 + i], saved[i]);
        single_write(20'h13579);

        // Random traffic against the model; a narrow select range makes hits common.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 599) == 0) do_reset(4'($urandom_range(0, 5)));
            step($urandom_range(0, 9) < 7, 4'($urandom_range(0, 5)), 20'($urandom),
                 $urandom_range(0, 9) < 3, 4'($urandom_range(0, 6)), 4'($urandom_range(0, 6)));
        end
        for (int i = 0; i < DEPTH + 1; i++) idle(1'b0, 4'd0, 4'd0);
        chk("final_empty", s_count, 3'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
